if_fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register; sits directly upstream of the ID stage and the hazard detection unit.
- Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid interface.
- Buffers returned instructions in a small prefetch FIFO and presents one {pc, inst} pair per cycle to decode.
- Freezes on the hazard-unit stall and flushes on a branch/jump redirect from EX.

---
 rtl/if_fetch_stage_if.sv | 25 ++
 rtl/if_fetch_stage.sv | 149 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and imem (slave).
// Signals: imem_req/imem_addr out of IF, imem_gnt/imem_rvalid/imem_rdata back.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage: owns the PC, fetches over imem (req/gnt/rvalid), prefetch FIFO, IF/ID reg.
// Ports: clk, rst (sync, high), imem (master), stall, redirect, redirect_pc, if_id_*.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    rst,
    if_fetch_stage_if.master        imem,
    input  logic                    stall,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    output logic                    if_id_valid,
    output logic [31:0]             if_id_pc,
    output logic [31:0]             if_id_inst
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   r_pc;

    // PCs of in-flight requests, consumed in order as responses return
    logic [31:0]   r_pcq [0:DEPTH-1];
    logic [AW-1:0] r_pcq_wr;
    logic [AW-1:0] r_pcq_rd;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_disc;

    // prefetch FIFO of {pc, inst}
    logic [63:0]   r_fifo [0:DEPTH-1];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;

    logic [CW:0]   w_sum;
    logic          w_req;
    logic          w_issue;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    assign w_sum    = {1'b0, r_out} + {1'b0, r_cnt};
    assign w_req    = !rst && !redirect && (w_sum < LIMIT);
    assign w_issue  = w_req && imem.imem_gnt;
    assign w_rsp    = imem.imem_rvalid && (r_out != '0);
    // stale words (from before a redirect) are never buffered
    assign w_push   = w_rsp && !redirect && (r_disc == '0);
    assign w_pop    = !redirect && !stall && (r_cnt != '0);
    assign w_unused = ^redirect_pc[1:0];

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
        end else if (w_issue) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_pcq[r_pcq_wr] <= r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcq_wr <= '0;
            r_pcq_rd <= '0;
            r_out    <= '0;
        end else begin
            if (w_issue) begin
                r_pcq_wr <= r_pcq_wr + AW'(1);
            end
            if (w_rsp) begin
                r_pcq_rd <= r_pcq_rd + AW'(1);
            end
            r_out <= r_out + CW'(w_issue) - CW'(w_rsp);
        end
    end

    // everything still in flight at a redirect, minus this cycle's word, is stale
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disc <= '0;
        end else if (redirect) begin
            r_disc <= r_out - CW'(w_rsp);
        end else if (w_rsp && (r_disc != '0)) begin
            r_disc <= r_disc - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr] <= {r_pcq[r_pcq_rd], imem.imem_rdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0;
            if_id_inst  <= NOP_INST;
        end else if (redirect) begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
        end else if (stall) begin
            if_id_valid <= if_id_valid;
        end else if (r_cnt != '0) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= r_fifo[r_rd][63:32];
            if_id_inst  <= r_fifo[r_rd][31:0];
        end else begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(w_push && (r_cnt == CW'(DEPTH)))
    );

    a_no_orphan_rsp: assert property (
        @(posedge clk) disable iff (rst) !(imem.imem_rvalid && (r_out == '0))
    );
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: latency-configurable imem model and
// an in-order {pc, inst} scoreboard checked at the IF/ID register.
module tb_if_fetch_stage;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;

    if_fetch_stage_if imem ();

    if_fetch_stage #(
        .RESET_PC (32'h0),
        .DEPTH    (DEPTH),
        .NOP_INST (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem.master),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_inst  (if_id_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        int          due;
    } rsp_t;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    rsp_t        mq[$];
    logic [63:0] exp_q[$];
    logic [31:0] m_pc = 32'h0;
    logic        p_rst = 1'b1;
    logic        p_stall = 1'b0;
    logic        p_redirect = 1'b0;
    logic        p_valid = 1'b0;
    logic [31:0] p_pc = 32'h0;
    logic [31:0] p_inst = 32'h0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ 32'h5EED_0000 ^ {a[9:2], 24'h0};
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // memory: fixed-latency, in-order responses
    initial begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            while (mq.size() > 0 && mq[0].due < cyc) mq.delete(0);
            #1;
            if (mq.size() > 0 && mq[0].due == cyc) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = mem_word(mq[0].a);
            end else begin
                imem.imem_rvalid = 1'b0;
                imem.imem_rdata  = $urandom;
            end
        end
    end

    // monitor / scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            check("rst_req", 64'(imem.imem_req), 64'd0);
            check("rst_valid", 64'(if_id_valid), 64'd0);
            check("rst_ifid", {if_id_pc, if_id_inst}, {32'h0, NOP});
            exp_q.delete();
            mq.delete();
            m_pc = 32'h0;
        end else begin
            if (p_rst) begin
                check("post_rst_v", 64'(if_id_valid), 64'd0);
                check("post_rst_pi", {if_id_pc, if_id_inst}, {32'h0, NOP});
            end else if (p_redirect) begin
                check("rdr_v", 64'(if_id_valid), 64'd0);
                check("rdr_pi", {if_id_pc, if_id_inst}, {p_pc, NOP});
            end else if (p_stall) begin
                check("hold_v", 64'(if_id_valid), 64'(p_valid));
                check("hold_pi", {if_id_pc, if_id_inst}, {p_pc, p_inst});
            end else if (if_id_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected", {if_id_pc, if_id_inst}, 64'd0);
                end else begin
                    check("ifid", {if_id_pc, if_id_inst}, exp_q.pop_front());
                end
            end else begin
                check("bub_inst", 64'(if_id_inst), 64'(NOP));
            end
            if (redirect) begin
                check("rdr_req", 64'(imem.imem_req), 64'd0);
            end
            if (imem.imem_req) begin
                check("addr", 64'(imem.imem_addr), 64'(m_pc));
                if (imem.imem_gnt) begin
                    exp_q.push_back({m_pc, mem_word(m_pc)});
                    mq.push_back('{m_pc, cyc + lat});
                    m_pc = m_pc + 32'd4;
                end
            end
            if (redirect) begin
                exp_q.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end
        end
        p_rst      = rst;
        p_stall    = stall;
        p_redirect = redirect;
        p_valid    = if_id_valid;
        p_pc       = if_id_pc;
        p_inst     = if_id_inst;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] a0;
        imem.imem_gnt = 1'b1;

        // reset and first-fetch latency
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (!if_id_valid && n < 20) begin
            tick();
            n++;
        end
        check("first_lat", 64'(n), 64'd3);
        check("first_out", {if_id_pc, if_id_inst}, {32'h0, mem_word(32'h0)});
        tick(6);

        // stall: fetch continues until full, then req drops
        stall = 1'b1;
        tick(2);
        check("stall_req", 64'(imem.imem_req), 64'd0);
        tick();
        stall = 1'b0;
        tick(6);

        // redirect with two fetches in flight
        lat = 2;
        tick(4);
        n = 0;
        while (mq.size() < 2 && n < 10) begin
            tick();
            n++;
        end
        check("two_out", 64'(mq.size()), 64'd2);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        check("rdr_bubble", 64'(if_id_valid), 64'd0);
        n = 0;
        while (!if_id_valid && n < 20) begin
            tick();
            n++;
        end
        check("rdr_first", {if_id_pc, if_id_inst},
              {32'h100, mem_word(32'h100)});
        tick(4);

        // redirect and stall together
        lat = 1;
        tick(4);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check("rs_bubble", {31'h0, if_id_valid, if_id_inst}, {32'h0, NOP});
        n = 0;
        while (!if_id_valid && n < 20) begin
            tick();
            n++;
        end
        check("rs_first", {if_id_pc, if_id_inst},
              {32'h200, mem_word(32'h200)});
        tick(4);

        // grant withheld
        imem.imem_gnt = 1'b0;
        tick(3);
        check("gnt_req", 64'(imem.imem_req), 64'd1);
        a0 = imem.imem_addr;
        repeat (4) begin
            tick();
            check("gnt_hold_req", 64'(imem.imem_req), 64'd1);
            check("gnt_hold_addr", 64'(imem.imem_addr), 64'(a0));
        end
        imem.imem_gnt = 1'b1;
        tick();
        check("gnt_adv", 64'(imem.imem_addr), 64'(a0 + 32'd4));
        tick(4);

        // PC wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("wrap0", 64'(imem.imem_addr), 64'(32'hFFFF_FFFC));
        tick();
        check("wrap1", 64'(imem.imem_addr), 64'd0);
        tick(6);

        // unaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        check("align", 64'(imem.imem_addr), 64'(32'h100));
        tick(6);

        // drain: everything fetched must have come out
        imem.imem_gnt = 1'b0;
        tick(8);
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
